// File: rtl/fpu_writeback.sv
// FPU writeback: in-order result queue draining to the FP and integer register files, with sticky fflags.
// Optional same-cycle bypass for a lone completion into an empty queue: define FPU_WB_BYPASS_EN.
module fpu_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [31:0] fpu_result_1,
    input  logic        fpu_complete,
    input  logic [31:0] fpu_result_rd,
    input  logic        fpu_complete_rd,
    input  logic [4:0]  wb_rd_addr,
    input  logic [4:0]  S_flag,
    input  logic        IV_exception,
    input  logic        gpr_wr_gnt,
    input  logic        csr_we,
    input  logic [4:0]  csr_wdata,
    output logic        wb_ready,
    output logic        fpr_we,
    output logic [4:0]  fpr_waddr,
    output logic [31:0] fpr_wdata,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic [4:0]  fflags,
    output logic        iv_trap,
    output logic [4:0]  wb_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 5;

    typedef struct packed {
        logic        is_int;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  flags;
        logic        iv;
    } wb_entry_t;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             ready_q, ready_d;

    wb_entry_t        head, fp_entry, int_entry;
    logic             active, empty, pop, byp;
    logic             push_fp, push_int;
    logic [CNT_W-1:0] occ_after_pop;
    logic [4:0]       acc_flags;

    assign active = ~rst_l;
    assign empty  = (count_q == '0);
    assign head   = mem_q[rd_ptr_q];

    assign fp_entry  = '{is_int: 1'b0, addr: wb_rd_addr, data: fpu_result_1,
                         flags: S_flag, iv: IV_exception};
    assign int_entry = '{is_int: 1'b1, addr: wb_rd_addr, data: fpu_result_rd,
                         flags: S_flag, iv: IV_exception};

    // Integer head waits for the grant and blocks everything behind it.
    assign pop = active && !empty && (!head.is_int || gpr_wr_gnt);

`ifdef FPU_WB_BYPASS_EN
    assign byp = active && empty && (fpu_complete ^ fpu_complete_rd)
                 && (fpu_complete || gpr_wr_gnt);
`else
    assign byp = 1'b0;
`endif

    // Space is judged after this cycle's pop; the FP entry claims a slot first.
    assign occ_after_pop = count_q - CNT_W'(pop);
    assign push_fp  = fpu_complete && !byp && (occ_after_pop < CNT_W'(DEPTH));
    assign push_int = fpu_complete_rd && !byp
                      && ((occ_after_pop + CNT_W'(push_fp)) < CNT_W'(DEPTH));

    // Write ports, trap pulse and next-state logic.
    always_comb begin
        fpr_we    = 1'b0;
        fpr_waddr = '0;
        fpr_wdata = '0;
        gpr_we    = 1'b0;
        gpr_waddr = '0;
        gpr_wdata = '0;
        iv_trap   = 1'b0;
        acc_flags = '0;

        if (pop) begin
            if (head.is_int) begin
                gpr_we    = 1'b1;
                gpr_waddr = head.addr;
                gpr_wdata = head.data;
            end else begin
                fpr_we    = 1'b1;
                fpr_waddr = head.addr;
                fpr_wdata = head.data;
            end
            iv_trap   = head.iv;
            acc_flags = head.flags;
        end else if (byp) begin
            if (fpu_complete) begin
                fpr_we    = 1'b1;
                fpr_waddr = wb_rd_addr;
                fpr_wdata = fpu_result_1;
            end else begin
                gpr_we    = 1'b1;
                gpr_waddr = wb_rd_addr;
                gpr_wdata = fpu_result_rd;
            end
            iv_trap   = IV_exception;
            acc_flags = S_flag;
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_fp) + PTR_W'(push_int);
        count_d  = count_q - CNT_W'(pop) + CNT_W'(push_fp) + CNT_W'(push_int);
        fflags_d = (csr_we ? csr_wdata : fflags_q) | acc_flags;
        ready_d  = (CNT_W'(DEPTH) - count_d) >= CNT_W'(2);
    end

    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage needs no reset: validity lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (push_fp) begin
            mem_q[wr_ptr_q] <= fp_entry;
        end
        if (push_int) begin
            mem_q[wr_ptr_q + PTR_W'(push_fp)] <= int_entry;
        end
    end

    assign wb_count = count_q;
    assign fflags   = fflags_q;
    assign wb_ready = ready_q;

endmodule

// File: tb/tb_fpu_writeback.sv
// Randomized and directed checks of fpu_writeback against a queue-based reference model.
module tb_fpu_writeback;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_l;
    logic [31:0] fpu_result_1;
    logic        fpu_complete;
    logic [31:0] fpu_result_rd;
    logic        fpu_complete_rd;
    logic [4:0]  wb_rd_addr;
    logic [4:0]  S_flag;
    logic        IV_exception;
    logic        gpr_wr_gnt;
    logic        csr_we;
    logic [4:0]  csr_wdata;
    logic        wb_ready;
    logic        fpr_we;
    logic [4:0]  fpr_waddr;
    logic [31:0] fpr_wdata;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [4:0]  fflags;
    logic        iv_trap;
    logic [4:0]  wb_count;

    fpu_writeback #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .fpu_result_1    (fpu_result_1),
        .fpu_complete    (fpu_complete),
        .fpu_result_rd   (fpu_result_rd),
        .fpu_complete_rd (fpu_complete_rd),
        .wb_rd_addr      (wb_rd_addr),
        .S_flag          (S_flag),
        .IV_exception    (IV_exception),
        .gpr_wr_gnt      (gpr_wr_gnt),
        .csr_we          (csr_we),
        .csr_wdata       (csr_wdata),
        .wb_ready        (wb_ready),
        .fpr_we          (fpr_we),
        .fpr_waddr       (fpr_waddr),
        .fpr_wdata       (fpr_wdata),
        .gpr_we          (gpr_we),
        .gpr_waddr       (gpr_waddr),
        .gpr_wdata       (gpr_wdata),
        .fflags          (fflags),
        .iv_trap         (iv_trap),
        .wb_count        (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        is_int;
        bit [4:0]  addr;
        bit [31:0] data;
        bit [4:0]  flags;
        bit        iv;
    } ent_t;

    ent_t     mq[$];
    bit [4:0] m_fflags;
    int       n_checks;
    int       n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model, then advance the model.
    task automatic step(input bit fc, input bit [31:0] fd, input bit ic, input bit [31:0] id,
                        input bit [4:0] a, input bit [4:0] fl, input bit iv, input bit g,
                        input bit cw, input bit [4:0] cd);
        bit   p;
        ent_t h;
        ent_t e;
        bit [4:0] add;
        @(negedge clk);
        fpu_complete = fc; fpu_result_1 = fd; fpu_complete_rd = ic; fpu_result_rd = id;
        wb_rd_addr = a; S_flag = fl; IV_exception = iv; gpr_wr_gnt = g;
        csr_we = cw; csr_wdata = cd;
        #1;
        check("wb_count", 32'(wb_count), 32'(mq.size()));
        check("fflags", 32'(fflags), 32'(m_fflags));
        check("wb_ready", 32'(wb_ready), 32'((DEPTH - mq.size()) >= 2));
        p = 1'b0;
        h = '{default: 0};
        if (mq.size() > 0) begin
            h = mq[0];
            p = !h.is_int || g;
        end
        check("fpr_we", 32'(fpr_we), 32'(p && !h.is_int));
        check("gpr_we", 32'(gpr_we), 32'(p && h.is_int));
        check("iv_trap", 32'(iv_trap), 32'(p && h.iv));
        if (p && !h.is_int) begin
            check("fpr_waddr", 32'(fpr_waddr), 32'(h.addr));
            check("fpr_wdata", fpr_wdata, h.data);
        end
        if (p && h.is_int) begin
            check("gpr_waddr", 32'(gpr_waddr), 32'(h.addr));
            check("gpr_wdata", gpr_wdata, h.data);
        end
        add = 5'd0;
        if (p) begin
            add = h.flags;
            void'(mq.pop_front());
        end
        m_fflags = (cw ? cd : m_fflags) | add;
        if (fc && mq.size() < DEPTH) begin
            e = '{is_int: 1'b0, addr: a, data: fd, flags: fl, iv: iv};
            mq.push_back(e);
        end
        if (ic && mq.size() < DEPTH) begin
            e = '{is_int: 1'b1, addr: a, data: id, flags: fl, iv: iv};
            mq.push_back(e);
        end
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, g, 0, 0);
    endtask

    task automatic reset_dut(input int hold);
        @(negedge clk);
        rst_l = 1'b1;
        fpu_complete = 0; fpu_complete_rd = 0; gpr_wr_gnt = 1; csr_we = 0;
        IV_exception = 0; S_flag = 0; wb_rd_addr = 0; fpu_result_1 = 0; fpu_result_rd = 0;
        csr_wdata = 0;
        mq.delete();
        m_fflags = 5'd0;
        for (int i = 0; i < hold; i++) begin
            #1;
            check("rst_count", 32'(wb_count), 0);
            check("rst_fflags", 32'(fflags), 0);
            check("rst_ready", 32'(wb_ready), 1);
            check("rst_we", 32'({fpr_we, gpr_we, iv_trap}), 0);
            check("rst_addr", 32'({fpr_waddr, gpr_waddr}), 0);
            check("rst_data", fpr_wdata | gpr_wdata, 0);
            @(negedge clk);
        end
        rst_l = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_dut(3);

        // Single FP completion.
        step(1, 32'h3F80_0000, 0, 0, 5'd5, 5'b00001, 0, 1, 0, 0);
        idle(2, 1);
        check("single_fflags", 32'(fflags), 32'h01);

        // Dual completion: FP first, then integer.
        step(1, 32'h4000_0000, 1, 32'h2, 5'd3, 5'd0, 0, 1, 0, 0);
        idle(3, 1);

        // Integer head stalls three FP completions behind it.
        step(0, 0, 1, 32'hCAFE_0001, 5'd7, 5'd0, 0, 0, 0, 0);
        step(1, 32'h1111_1111, 0, 0, 5'd8, 5'd0, 0, 0, 0, 0);
        step(1, 32'h2222_2222, 0, 0, 5'd9, 5'd0, 0, 0, 0, 0);
        step(1, 32'h3333_3333, 0, 0, 5'd10, 5'd0, 0, 0, 0, 0);
        idle(2, 0);
        check("stall_count", 32'(wb_count), 4);
        check("stall_ready", 32'(wb_ready), 0);
        idle(6, 1);

        // Software clears fflags in the same cycle a pop sets NV.
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111);
        step(1, 32'h7FC0_0000, 0, 0, 5'd2, 5'b10000, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000);
        idle(1, 1);
        check("csr_pop_fflags", 32'(fflags), 32'h10);

        // Invalid-operation trap pulse.
        step(1, 32'h7FC0_0000, 0, 0, 5'd4, 5'b10000, 1, 1, 0, 0);
        idle(3, 1);

        // Reset with three queued integer entries, then normal operation.
        step(0, 0, 1, 32'hA, 5'd1, 5'b00100, 1, 0, 0, 0);
        step(0, 0, 1, 32'hB, 5'd2, 5'b00100, 0, 0, 0, 0);
        step(0, 0, 1, 32'hC, 5'd3, 5'b00100, 0, 0, 0, 0);
        reset_dut(2);
        step(1, 32'h3F80_0000, 0, 0, 5'd6, 5'b00010, 0, 1, 0, 0);
        idle(2, 1);

        // Random traffic, including overflow drops and full-queue push/pop.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, $urandom, ($urandom % 3) == 0, $urandom,
                 5'($urandom), 5'($urandom), ($urandom % 8) == 0, ($urandom % 5) < 3,
                 ($urandom % 16) == 0, 5'($urandom));
        end
        idle(DEPTH + 2, 1);
        check("drain_count", 32'(wb_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_writeback.md
FPU_WRITEBACK -- requirements
Module: fpu_writeback

Interface
REQ-001 Parameter DEPTH, default 4, number of result-queue entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_l  input  1  asynchronous, active-high reset (asserted = 1).
REQ-004 fpu_result_1  input  32  FP result from the execution stage.
REQ-005 fpu_complete  input  1  fpu_result_1 valid this cycle.
REQ-006 fpu_result_rd  input  32  integer result from the execution stage.
REQ-007 fpu_complete_rd  input  1  fpu_result_rd valid this cycle.
REQ-008 wb_rd_addr  input  5  destination register of the completing operation.
REQ-009 S_flag  input  5  exception flags {NV,DZ,OF,UF,NX} of the completing operation.
REQ-010 IV_exception  input  1  invalid-operation trap request of the completing operation.
REQ-011 gpr_wr_gnt  input  1  integer register file accepts a write this cycle.
REQ-012 csr_we  input  1  software write of fflags.
REQ-013 csr_wdata  input  5  fflags write data.
REQ-014 wb_ready  output  1  queue can accept a completion next cycle.
REQ-015 fpr_we, fpr_waddr, fpr_wdata  output  1/5/32  FP register file write port.
REQ-016 gpr_we, gpr_waddr, gpr_wdata  output  1/5/32  integer register file write port.
REQ-017 fflags  output  5  sticky accrued exception flags.
REQ-018 iv_trap  output  1  one-cycle invalid-operation trap pulse.
REQ-019 wb_count  output  5  current queue occupancy.

Function
REQ-020 Each completion SHALL push one entry {is_int, addr, data, flags, iv} into an in-order FIFO; fpu_complete pushes is_int=0 with fpu_result_1, fpu_complete_rd pushes is_int=1 with fpu_result_rd.
REQ-021 When both completes are high in one cycle, two entries SHALL be pushed, FP entry first; both carry the same addr, flags and iv.
REQ-022 wb_ready SHALL be 1 iff free entries >= 2, registered from occupancy after this cycle's push and pop.
REQ-023 A push while the queue lacks space is an upstream error; the entry SHALL be dropped and the queue SHALL remain uncorrupted.
REQ-024 The head entry SHALL pop when it is FP (fpr port always accepts) or when it is integer and gpr_wr_gnt=1; at most one pop per cycle.
REQ-025 On a pop the matching write port SHALL assert we for that cycle with the head addr/data; the other port's we SHALL be 0.
REQ-026 An integer head with gpr_wr_gnt=0 SHALL stall the entire queue; no later FP entry bypasses it.
REQ-027 Push-to-write latency SHALL be one cycle minimum: an entry pushed in cycle N writes no earlier than cycle N+1.
REQ-028 Push and pop in the same cycle at full or empty SHALL be handled; read/write pointers wrap modulo DEPTH.
REQ-029 fflags next = (csr_we ? csr_wdata : fflags) | (pop ? head.flags : 0); flags accrue at pop, not at push.
REQ-030 iv_trap SHALL pulse 1 in the cycle an entry with iv=1 pops, otherwise 0.
REQ-031 wb_count SHALL equal pushes minus pops since reset, range 0..DEPTH.

Reset
REQ-032 While rst_l=1: queue empty, pointers 0, wb_count=0, fflags=0, all we outputs 0, addr/data outputs 0, iv_trap=0, wb_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries immediately, with no write issued.

Configuration
REQ-034 Macro FPU_WB_BYPASS_EN: when defined, a single completion arriving with the queue empty and its target port available SHALL be written in the same cycle without being enqueued; flags and iv apply in that cycle.
REQ-035 Without FPU_WB_BYPASS_EN every completion SHALL be enqueued, and REQ-027 latency applies.

Verification
REQ-036 Single FP: fpu_complete=1, data 0x3F800000, addr 5, S_flag=00001 -> next cycle fpr_we=1, waddr 5, wdata 0x3F800000; fflags=00001 one cycle later (same cycle under bypass).
REQ-037 Dual complete: both completes, addr 3, FP 0x40000000, int 0x00000002, gpr_wr_gnt=1 -> FPR write, then GPR write on the following cycle, wb_count 2->1->0.
REQ-038 Stall: integer head with gpr_wr_gnt=0 for 6 cycles while 3 FP completions arrive -> no writes, wb_count reaches 4, wb_ready=0; after the grant, writes drain in order.
REQ-039 Flags: csr_we with 00000 in the same cycle a pop with flags 10000 occurs -> fflags=10000; IV_exception entry pops -> iv_trap is a one-cycle pulse.
REQ-040 Reset: assert rst_l with 3 entries queued -> wb_count=0, no we pulses, fflags=0; after release a new completion writes normally.
